// File: rtl/spi_rr_arbiter.sv
// Round-robin arbiter sharing one SPI engine between three requesters
// (init sequencer, delay tuner, host). Latches the winning request, drives
// the engine, routes the raw chip-enable to the addressed device and returns
// a one-cycle ack with error and read-data status.
module spi_rr_arbiter #(
    parameter logic [19:0] TIMEOUT_CYCLES = 20'd200000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  req,
    input  logic [5:0]  req_dev,
    input  logic [47:0] req_addr,
    input  logic [23:0] req_wdata,
    input  logic [2:0]  req_rd,
    output logic [2:0]  grant,
    output logic [2:0]  ack,
    output logic        err,
    output logic [7:0]  rdata,
    output logic        eng_start,
    output logic [15:0] eng_addr,
    output logic [7:0]  eng_wdata,
    output logic        eng_rd,
    output logic        eng_three_wire,
    output logic        eng_addr_2byte,
    input  logic        eng_done,
    input  logic [7:0]  eng_rdata,
    input  logic        eng_ce,
    output logic        clk_spi_ce,
    output logic        dac1_spi_ce,
    output logic        dac2_spi_ce
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_ACK   = 2'd3;

    localparam logic [1:0] DEV_AD9518  = 2'd0;
    localparam logic [1:0] DEV_DAC1    = 2'd1;
    localparam logic [1:0] DEV_DAC2    = 2'd2;
    localparam logic [1:0] DEV_INVALID = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [2:0]  grant_q, grant_d;
    logic [2:0]  ack_q, ack_d;
    logic        err_q, err_d;
    logic        err_pend_q, err_pend_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        start_q, start_d;
    logic [1:0]  dev_q, dev_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        rd_q, rd_d;
    logic        mode_q, mode_d;
    logic [1:0]  last_q, last_d;
    logic [19:0] cnt_q, cnt_d;

    logic [2:0]  eligible;
    logic        pick_vld;
    logic [1:0]  pick_idx;
    logic [1:0]  cand;
    logic [1:0]  sel_dev;
    logic [15:0] sel_addr;
    logic [7:0]  sel_wdata;
    logic        sel_rd;
    logic [19:0] cnt_inc;
    logic        timeout;
    logic        ce_active;

    // Round-robin pick starting after the last granted requester. The requester
    // being acked this cycle is masked: its req is still high until it sees ack.
    always_comb begin
        eligible = req & ~ack_q;
        pick_vld = 1'b0;
        pick_idx = '0;
        cand     = '0;
        for (int unsigned k = 0; k < 3; k++) begin
            cand = 2'((32'(last_q) + 32'd1 + k) % 32'd3);
            if (!pick_vld && eligible[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end
    end

    // Select the winning requester's transaction fields.
    always_comb begin
        sel_dev   = DEV_INVALID;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_rd    = 1'b0;
        for (int unsigned k = 0; k < 3; k++) begin
            if (pick_idx == 2'(k)) begin
                sel_dev   = req_dev[2*k +: 2];
                sel_addr  = req_addr[16*k +: 16];
                sel_wdata = req_wdata[8*k +: 8];
                sel_rd    = req_rd[k];
            end
        end
    end

    // Saturating timeout counter; fires on the edge the count reaches TIMEOUT_CYCLES-1.
    always_comb begin
        cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 20'd1;
        timeout = (cnt_inc == TIMEOUT_CYCLES - 20'd1);
    end

    // Next-state logic for the arbiter FSM and its datapath registers.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        ack_d      = '0;
        err_d      = 1'b0;
        err_pend_d = err_pend_q;
        rdata_d    = rdata_q;
        start_d    = 1'b0;
        dev_d      = dev_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rd_d       = rd_q;
        mode_d     = mode_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (pick_vld) begin
                    grant_d = 3'b001 << pick_idx;
                    dev_d   = sel_dev;
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                    rd_d    = sel_rd;
                    mode_d  = (sel_dev == DEV_AD9518);
                    cnt_d   = '0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (dev_q == DEV_INVALID) begin
                    err_pend_d = 1'b1;
                    state_d    = S_ACK;
                end else begin
                    start_d    = 1'b1;
                    err_pend_d = 1'b0;
                    cnt_d      = '0;
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                // Completion takes priority over a simultaneous timeout.
                if (eng_done) begin
                    if (rd_q) begin
                        rdata_d = eng_rdata;
                    end
                    err_pend_d = 1'b0;
                    state_d    = S_ACK;
                end else if (timeout) begin
                    err_pend_d = 1'b1;
                    state_d    = S_ACK;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                ack_d   = grant_q;
                err_d   = err_pend_q;
                grant_d = '0;
                last_d  = grant_q[1] ? 2'd1 : (grant_q[2] ? 2'd2 : 2'd0);
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            grant_q    <= '0;
            ack_q      <= '0;
            err_q      <= 1'b0;
            err_pend_q <= 1'b0;
            rdata_q    <= '0;
            start_q    <= 1'b0;
            dev_q      <= DEV_INVALID;
            addr_q     <= '0;
            wdata_q    <= '0;
            rd_q       <= 1'b0;
            mode_q     <= 1'b0;
            last_q     <= 2'd2;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            err_pend_q <= err_pend_d;
            rdata_q    <= rdata_d;
            start_q    <= start_d;
            dev_q      <= dev_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rd_q       <= rd_d;
            mode_q     <= mode_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
        end
    end

    // Route the raw chip-enable only to the latched device while a transfer is live.
    always_comb begin
        ce_active   = (state_q == S_ISSUE) || (state_q == S_WAIT);
        clk_spi_ce  = (ce_active && dev_q == DEV_AD9518) ? eng_ce : 1'b1;
        dac1_spi_ce = (ce_active && dev_q == DEV_DAC1)   ? eng_ce : 1'b1;
        dac2_spi_ce = (ce_active && dev_q == DEV_DAC2)   ? eng_ce : 1'b1;
    end

    assign grant          = grant_q;
    assign ack            = ack_q;
    assign err            = err_q;
    assign rdata          = rdata_q;
    assign eng_start      = start_q;
    assign eng_addr       = addr_q;
    assign eng_wdata      = wdata_q;
    assign eng_rd         = rd_q;
    assign eng_three_wire = mode_q;
    assign eng_addr_2byte = mode_q;

endmodule

// File: tb/tb_spi_rr_arbiter.sv
// Directed bench for spi_rr_arbiter: round-robin order, device routing,
// read capture, invalid device, timeout and mid-transaction reset.
module tb_spi_rr_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  req = '0;
    logic [5:0]  req_dev = '0;
    logic [47:0] req_addr = '0;
    logic [23:0] req_wdata = '0;
    logic [2:0]  req_rd = '0;
    logic [2:0]  grant;
    logic [2:0]  ack;
    logic        err;
    logic [7:0]  rdata;
    logic        eng_start;
    logic [15:0] eng_addr;
    logic [7:0]  eng_wdata;
    logic        eng_rd;
    logic        eng_three_wire;
    logic        eng_addr_2byte;
    logic        eng_done = 1'b0;
    logic [7:0]  eng_rdata = '0;
    logic        eng_ce = 1'b1;
    logic        clk_spi_ce;
    logic        dac1_spi_ce;
    logic        dac2_spi_ce;

    int checks = 0;
    int errors = 0;

    spi_rr_arbiter #(.TIMEOUT_CYCLES(20'd16)) dut (
        .clk(clk), .rst(rst), .req(req), .req_dev(req_dev), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_rd(req_rd), .grant(grant), .ack(ack), .err(err),
        .rdata(rdata), .eng_start(eng_start), .eng_addr(eng_addr), .eng_wdata(eng_wdata),
        .eng_rd(eng_rd), .eng_three_wire(eng_three_wire), .eng_addr_2byte(eng_addr_2byte),
        .eng_done(eng_done), .eng_rdata(eng_rdata), .eng_ce(eng_ce),
        .clk_spi_ce(clk_spi_ce), .dac1_spi_ce(dac1_spi_ce), .dac2_spi_ce(dac2_spi_ce)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for any grant, then compare against the expected one-hot.
    task automatic wait_grant(input string tag, input logic [2:0] exp);
        for (int i = 0; i < 8; i++) begin
            if (grant != 3'b000) break;
            tick();
        end
        chk(tag, 16'(grant), 16'(exp));
    endtask

    // Engine model: done sampled 10 cycles after the start pulse; ends on the ack cycle.
    task automatic engine_txn(input string tag, input logic [7:0] rd);
        for (int i = 0; i < 8; i++) begin
            if (eng_start) break;
            tick();
        end
        chk(tag, 16'(eng_start), 16'd1);
        repeat (9) tick();
        eng_done  = 1'b1;
        eng_rdata = rd;
        tick();
        eng_done = 1'b0;
        tick();
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        chk("rst_grant", 16'(grant), 16'd0);
        chk("rst_ack", 16'(ack), 16'd0);
        chk("rst_err", 16'(err), 16'd0);
        chk("rst_start", 16'(eng_start), 16'd0);
        chk("rst_mode", 16'({eng_three_wire, eng_addr_2byte}), 16'd0);
        chk("rst_ce", 16'({clk_spi_ce, dac1_spi_ce, dac2_spi_ce}), 16'h7);
        rst = 1'b0;
        tick();

        // Round-robin with all three requesting: 0, 1, 2, 0
        req_dev = 6'b01_01_01;
        req     = 3'b111;
        wait_grant("rr_g0", 3'b001);
        engine_txn("rr_s0", 8'h00);
        chk("rr_ack0", 16'(ack), 16'h1);
        chk("rr_err0", 16'(err), 16'd0);
        tick();
        chk("rr_ack0_w", 16'(ack), 16'd0);
        wait_grant("rr_g1", 3'b010);
        engine_txn("rr_s1", 8'h00);
        chk("rr_ack1", 16'(ack), 16'h2);
        tick();
        chk("rr_ack1_w", 16'(ack), 16'd0);
        wait_grant("rr_g2", 3'b100);
        engine_txn("rr_s2", 8'h00);
        chk("rr_ack2", 16'(ack), 16'h4);
        tick();
        wait_grant("rr_g3", 3'b001);
        engine_txn("rr_s3", 8'h00);
        chk("rr_ack3", 16'(ack), 16'h1);
        req = 3'b000;
        tick();
        chk("rr_ack3_w", 16'(ack), 16'd0);

        // Requester 1 writes AD9518 register 0x0232
        req_dev[3:2]    = 2'd0;
        req_addr[31:16] = 16'h0232;
        req_wdata[15:8] = 8'h01;
        req_rd[1]       = 1'b0;
        req             = 3'b010;
        wait_grant("ad_grant", 3'b010);
        eng_ce = 1'b0;
        #1;
        chk("ad_mode", 16'({eng_three_wire, eng_addr_2byte}), 16'h3);
        chk("ad_addr", eng_addr, 16'h0232);
        chk("ad_wdata", 16'(eng_wdata), 16'h01);
        chk("ad_rd", 16'(eng_rd), 16'd0);
        chk("ad_ce", 16'({clk_spi_ce, dac1_spi_ce, dac2_spi_ce}), 16'h3);
        req_addr[31:16] = 16'hBEEF;
        engine_txn("ad_start", 8'h55);
        chk("ad_ack", 16'(ack), 16'h2);
        chk("ad_err", 16'(err), 16'd0);
        chk("ad_addr_hold", eng_addr, 16'h0232);
        chk("ad_ce_idle", 16'({clk_spi_ce, dac1_spi_ce, dac2_spi_ce}), 16'h7);
        chk("ad_rdata_wr", 16'(rdata), 16'h00);
        req    = 3'b000;
        eng_ce = 1'b1;
        tick();

        // Requester 2 reads DAC2
        req_dev[5:4] = 2'd2;
        req_rd[2]    = 1'b1;
        req          = 3'b100;
        wait_grant("d2_grant", 3'b100);
        eng_ce = 1'b0;
        #1;
        chk("d2_ce", 16'({clk_spi_ce, dac1_spi_ce, dac2_spi_ce}), 16'h6);
        chk("d2_mode", 16'({eng_three_wire, eng_addr_2byte}), 16'd0);
        engine_txn("d2_start", 8'hA5);
        chk("d2_ack", 16'(ack), 16'h4);
        chk("d2_rdata", 16'(rdata), 16'hA5);
        chk("d2_err", 16'(err), 16'd0);
        req    = 3'b000;
        eng_ce = 1'b1;
        tick();

        // Requester 0 targets the invalid device
        req_dev[1:0] = 2'd3;
        req          = 3'b001;
        eng_ce       = 1'b0;
        wait_grant("inv_grant", 3'b001);
        chk("inv_start0", 16'(eng_start), 16'd0);
        chk("inv_ce", 16'({clk_spi_ce, dac1_spi_ce, dac2_spi_ce}), 16'h7);
        tick();
        chk("inv_start1", 16'(eng_start), 16'd0);
        chk("inv_ack_early", 16'(ack), 16'd0);
        tick();
        chk("inv_ack", 16'(ack), 16'h1);
        chk("inv_err", 16'(err), 16'd1);
        chk("inv_rdata", 16'(rdata), 16'hA5);
        req    = 3'b000;
        eng_ce = 1'b1;
        tick();
        chk("inv_err_clr", 16'(err), 16'd0);

        // Timeout on DAC1: ack 16 cycles after the start pulse, late done ignored
        req_dev[3:2] = 2'd1;
        req          = 3'b010;
        wait_grant("to_grant", 3'b010);
        tick();
        chk("to_start", 16'(eng_start), 16'd1);
        repeat (15) tick();
        chk("to_ack_early", 16'(ack), 16'd0);
        tick();
        chk("to_ack", 16'(ack), 16'h2);
        chk("to_err", 16'(err), 16'd1);
        req       = 3'b000;
        eng_done  = 1'b1;
        eng_rdata = 8'h3C;
        tick();
        chk("to_late_grant", 16'(grant), 16'd0);
        chk("to_late_ack", 16'(ack), 16'd0);
        chk("to_late_rdata", 16'(rdata), 16'hA5);
        eng_done = 1'b0;
        tick();

        // Reset asserted while waiting on the engine
        req_dev[5:4] = 2'd2;
        req          = 3'b100;
        wait_grant("mr_grant", 3'b100);
        tick();
        eng_ce = 1'b0;
        #1;
        chk("mr_ce_live", 16'(dac2_spi_ce), 16'd0);
        rst = 1'b1;
        #1;
        chk("mr_grant0", 16'(grant), 16'd0);
        chk("mr_rdata", 16'(rdata), 16'd0);
        chk("mr_start", 16'(eng_start), 16'd0);
        chk("mr_addr", eng_addr, 16'd0);
        chk("mr_ce", 16'({clk_spi_ce, dac1_spi_ce, dac2_spi_ce}), 16'h7);
        eng_ce = 1'b1;
        tick();
        @(negedge clk);
        rst = 1'b0;
        req = 3'b111;
        wait_grant("mr_first", 3'b001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_rr_arbiter.md
SPI_RR_ARBITER -- requirements
Module: spi_rr_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 20'd200000: maximum cycles to wait for eng_done after eng_start.
REQ-002 Port clk, input, 1: single clock for all logic.
REQ-003 Port rst, input, 1: asynchronous, active-high reset.
REQ-004 Port req, input, 3: request bit per requester (0 = init sequencer, 1 = delay tuner, 2 = host); each bit held high until its ack.
REQ-005 Port req_dev, input, 6: 2-bit target per requester at [2i+1:2i]; 0 = AD9518, 1 = DAC1, 2 = DAC2, 3 = invalid.
REQ-006 Port req_addr, input, 48: 16-bit register address per requester at [16i+15:16i].
REQ-007 Port req_wdata, input, 24: 8-bit write data per requester.
REQ-008 Port req_rd, input, 3: 1 = read access, 0 = write access, one bit per requester.
REQ-009 Port grant, output, 3: one-hot grant, high from latch until ack.
REQ-010 Port ack, output, 3: one-cycle completion pulse to the granted requester.
REQ-011 Port err, output, 1: valid with ack; set on timeout or invalid device.
REQ-012 Port rdata, output, 8: read data, valid with ack.
REQ-013 Port eng_start, output, 1: one-cycle start pulse to the shared SPI engine.
REQ-014 Ports eng_addr (16), eng_wdata (8), eng_rd (1), eng_three_wire (1), eng_addr_2byte (1), all outputs: transaction fields driven to the engine.
REQ-015 Ports eng_done (1), eng_rdata (8), eng_ce (1), all inputs: engine completion pulse, read data, and raw chip-enable.
REQ-016 Ports clk_spi_ce, dac1_spi_ce, dac2_spi_ce, outputs, 1 each: active-low per-device chip enables.

Function
REQ-017 FSM states: IDLE, ISSUE, WAIT, ACK.
REQ-018 IDLE, req != 0: choose the requester by round-robin, starting search at (last_grant + 1) mod 3.
  - latch its dev/addr/wdata/rd
  - assert grant
  - go to ISSUE
REQ-019 IDLE, req == 0: stay in IDLE; last_grant unchanged.
REQ-020 ISSUE, latched dev == 3: no eng_start; set err = 1; go to ACK.
REQ-021 ISSUE, dev valid: pulse eng_start for exactly one cycle; clear timeout counter; go to WAIT.
REQ-022 Engine mode from latched dev:
  - dev 0: eng_three_wire = 1, eng_addr_2byte = 1
  - dev 1/2: both 0
  - held stable from ISSUE through ACK
REQ-023 WAIT, eng_done = 1: capture eng_rdata into rdata (read only; write leaves rdata unchanged); err = 0; go to ACK.
REQ-024 WAIT, counter reaches TIMEOUT_CYCLES-1 without eng_done: err = 1; go to ACK.
REQ-025 eng_done and timeout on the same cycle: eng_done wins, err = 0.
REQ-026 ACK: pulse ack[granted] for one cycle; deassert grant; update last_grant; return to IDLE.
  - Minimum request-to-request turnaround: one IDLE cycle.
REQ-027 Chip-enable routing: only the latched device's CE follows eng_ce, and only in ISSUE/WAIT; all others held 1.
  - In IDLE/ACK, and for dev 3, all three CEs are 1.
REQ-028 Request deasserted while granted: no effect; the transaction completes and ack still pulses.
REQ-029 Latched fields are not affected by req_* changes after the grant.
REQ-030 eng_done while not in WAIT: ignored.
REQ-031 Timeout counter is 20 bits; saturates and never wraps.

Reset
REQ-032 rst = 1 resets immediately, including mid-transaction:
  - state = IDLE; grant = 0, ack = 0, err = 0, rdata = 0, eng_start = 0
  - eng_addr = 0, eng_wdata = 0, eng_rd = 0, eng_three_wire = 0, eng_addr_2byte = 0
  - all CEs = 1
  - last_grant = 2, so requester 0 wins first
REQ-033 After rst release: the first grant occurs no earlier than the cycle following the first clk edge with req != 0.

Verification
REQ-034 req = 3'b111 after reset, engine done 10 cycles after each start -> grants in order 0, 1, 2, 0; each ack one cycle wide.
REQ-035 Requester 1, dev = 0, addr = 16'h0232, wdata = 8'h01, write -> eng_three_wire = 1, eng_addr_2byte = 1, clk_spi_ce follows eng_ce, dac CEs stay 1, err = 0.
REQ-036 Requester 2, dev = 2, read, eng_rdata = 8'hA5 with eng_done -> ack[2] pulse, rdata = 8'hA5, only dac2_spi_ce toggles.
REQ-037 Requester 0, dev = 3 -> no eng_start, ack[0] with err = 1 exactly 2 cycles after grant, all CEs 1.
REQ-038 TIMEOUT_CYCLES = 16, engine never signals done -> ack with err = 1 exactly 16 cycles after eng_start; eng_done arriving later is ignored.
REQ-039 rst asserted during WAIT -> all outputs at reset values the same cycle; a new req after release is granted to requester 0 first.
